// File: rtl/gru_pkg.sv
// Shared constants and FSM encoding for the GRU cell activation path.
package gru_pkg;

    localparam int FP_W         = 32;
    localparam int TANH_LATENCY = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gnt_idx
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/tanh_share_ctrl.sv
// Shares one tanh unit between N_REQ requesters: round-robin accept,
// single start pulse, watchdog-bounded wait, one-hot result strobe.
module tanh_share_ctrl
    import gru_pkg::state_t;
    import gru_pkg::S_IDLE;
    import gru_pkg::S_ISSUE;
    import gru_pkg::S_WAIT;
    import gru_pkg::S_RESP;
#(
    parameter int N_REQ   = 4,
    parameter int FP_W    = 32,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FP_W-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [FP_W-1:0]         resp_data,
    output logic                    resp_err,
    output logic                    tanh_start,
    output logic [FP_W-1:0]         tanh_in,
    input  logic [FP_W-1:0]         tanh_out,
    input  logic                    tanh_done,
    output logic                    busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr, grant, gnt_idx;
    logic [CW-1:0]    wait_cnt;
    logic [N_REQ-1:0] gnt;
    logic             arb_en, accept, timeout_hit;
    logic [FP_W-1:0]  slot [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot[i] = req_data[i*FP_W +: FP_W];
    end

    // Gating with rstn keeps req_ready low while reset is held.
    assign arb_en      = (state == S_IDLE) && rstn;
    assign accept      = |gnt;
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign req_ready   = gnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (tanh_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tanh_start = (state == S_ISSUE);
        busy       = (state != S_IDLE);
        resp_valid = '0;
        if (state == S_RESP) resp_valid[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= PW'(N_REQ - 1);
            grant     <= '0;
            tanh_in   <= '0;
            wait_cnt  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    grant   <= gnt_idx;
                    tanh_in <= slot[gnt_idx];
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    // done takes priority over a coincident watchdog expiry
                    if (tanh_done) begin
                        resp_data <= tanh_out;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                S_RESP: rr_ptr <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_share_ctrl.sv
// Directed plus random bench for tanh_share_ctrl with a behavioural tanh unit.
module tb_tanh_share_ctrl;
    import gru_pkg::*;

    localparam int N  = 4;
    localparam int FW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*FW-1:0]   req_data;
    logic [N-1:0]      req_ready, resp_valid;
    logic [FW-1:0]     resp_data, tanh_in, tanh_out;
    logic              resp_err, tanh_start, tanh_done, busy;
    logic [FW-1:0]     din [N];

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int last   = N - 1;
    int acc_at = 0;
    int lat    = TANH_LATENCY;
    int cd     = 0;
    bit stray  = 1'b0;
    logic [FW-1:0] op;

    for (genvar i = 0; i < N; i++) begin : g_din
        assign req_data[i*FW +: FW] = din[i];
    end

    tanh_share_ctrl #(.N_REQ(N), .FP_W(FW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .tanh_start (tanh_start),
        .tanh_in    (tanh_in),
        .tanh_out   (tanh_out),
        .tanh_done  (tanh_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] tanh_ref(input logic [31:0] x);
        case (x)
            32'h3F800000: return 32'h3F42F7D6;
            32'hBF800000: return 32'hBF42F7D6;
            32'h41200000: return 32'h3F800000;
            default:      return {x[31], x[30:0] >> 1} ^ 32'h0000_5A5A;
        endcase
    endfunction

    function automatic int ref_grant(input logic [N-1:0] v, input int after);
        for (int k = 1; k <= N; k++)
            if (v[(after + k) % N]) return (after + k) % N;
        return -1;
    endfunction

    // tanh unit: done pulses lat cycles after the start cycle; lat==0 never answers
    initial begin
        tanh_done = 1'b0;
        tanh_out  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) cd = 0;
            else if (tanh_start) begin
                op = tanh_in;
                cd = lat;
            end
            @(posedge clk); #1;
            tanh_done = 1'b0;
            tanh_out  = $urandom;
            if (stray) begin
                tanh_done = 1'b1;
                stray     = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tanh_done = 1'b1;
                    tanh_out  = tanh_ref(op);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input logic [N-1:0] nv, input int L, input bit keep, input string tag);
        int g, exp_lat;
        logic [N-1:0] one_g;
        logic [31:0] opnd, exp_d;
        logic exp_e;
        g       = ref_grant(nv, last);
        one_g   = '0;
        one_g[g] = 1'b1;
        exp_e   = !(L >= 1 && L <= TO);
        exp_lat = exp_e ? 2 + TO : 2 + L;
        @(posedge clk); #1;
        req_valid = nv;
        lat       = L;
        @(negedge clk);
        acc_at = cyc_n;
        chk({tag, "_ready"}, req_ready, one_g);
        opnd  = din[g];
        exp_d = exp_e ? 32'h0 : tanh_ref(opnd);
        @(posedge clk); #1;
        if (!keep) req_valid[g] = 1'b0;
        @(negedge clk);
        chk({tag, "_issue"}, {tanh_start, busy, |req_ready}, 3'b110);
        chk({tag, "_tin"}, tanh_in, opnd);
        for (int c = 2; c <= exp_lat; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c < exp_lat)
                chk({tag, "_quiet"}, {resp_valid, tanh_start, req_ready}, '0);
            else begin
                chk({tag, "_rvalid"}, resp_valid, one_g);
                chk({tag, "_rdata"}, resp_data, exp_d);
                chk({tag, "_rerr"}, resp_err, exp_e);
                chk({tag, "_hold"}, {tanh_in, busy}, {opnd, 1'b1});
            end
        end
        last = g;
    endtask

    initial begin
        int prev;
        for (int i = 0; i < N; i++) din[i] = $urandom;

        // reset state, with requests pending to show req_ready stays low
        req_valid = '1;
        @(negedge clk);
        chk("rst_ctl", {req_ready, resp_valid, tanh_start, busy, resp_err}, '0);
        chk("rst_data", {resp_data, tanh_in}, '0);
        req_valid = '0;
        @(posedge clk); #1;
        rstn = 1'b1;

        // single request, nominal latency
        din[0] = 32'h3F800000;
        serve(4'b0001, TANH_LATENCY, 1'b0, "single");
        chk("single_lat", cyc_n - acc_at, 5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_after", {resp_valid, busy}, '0);
        chk("single_held", {resp_data, resp_err}, {32'h3F42F7D6, 1'b0});

        // sign and saturation
        din[2] = 32'hBF800000;
        serve(4'b0100, TANH_LATENCY, 1'b0, "neg");
        chk("neg_data", resp_data, 32'hBF42F7D6);
        din[3] = 32'h41200000;
        serve(4'b1000, TANH_LATENCY, 1'b0, "sat");
        chk("sat_data", {resp_data, resp_err}, {32'h3F800000, 1'b0});

        // watchdog expiry, then the other pending requester is served
        serve(4'b0011, 0, 1'b0, "tmo");
        chk("tmo_lat", cyc_n - acc_at, 2 + TO);
        serve(4'b0010, TANH_LATENCY, 1'b0, "tmo_next");

        // stray done while idle
        req_valid = '0;
        stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stray", {resp_valid, busy}, '0);
        end

        // done coincident with the last watchdog cycle
        din[0] = $urandom;
        serve(4'b0001, TO, 1'b0, "edge");
        chk("edge_err", resp_err, 1'b0);

        // random operands, masks and latencies (including late/never done)
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) din[i] = $urandom;
            serve(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, TO + 1), 1'b0, "rnd");
        end

        // reset during WAIT; rr pointer must return to its reset value
        serve(4'b0100, TANH_LATENCY, 1'b0, "pre_rst");
        din[1] = $urandom;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        lat = TANH_LATENCY;
        @(negedge clk);
        chk("mid_acc", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        req_valid = '1;
        #1;
        chk("mid_rst_ctl", {req_ready, resp_valid, tanh_start, busy, resp_err}, '0);
        chk("mid_rst_data", {resp_data, tanh_in}, '0);
        @(posedge clk); #1;
        req_valid = '0;
        rstn = 1'b1;
        last = N - 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst", {resp_valid, busy}, '0);
            @(posedge clk); #1;
        end

        // fairness: all requesters held, grants 0,1,2,3,0 six cycles apart
        for (int i = 0; i < N; i++) din[i] = $urandom;
        serve(4'b1111, TANH_LATENCY, 1'b1, "rr");
        for (int k = 1; k < 5; k++) begin
            prev = acc_at;
            serve(4'b1111, TANH_LATENCY, 1'b1, "rr");
            chk("rr_gap", acc_at - prev, 6);
        end
        chk("rr_last", last, 0);

        req_valid = '0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tanh_share_ctrl.md
Name: tanh_share_ctrl

Overview:
Round-robin controller that shares one tanh LUT unit (start/done handshake, 32-bit IEEE-754 in/out) between N_REQ requesters, such as the GRU candidate-state and output-state paths.
- Accepts one request at a time, sequences the single-cycle start pulse, and waits for done with a watchdog.
- Returns the result one-hot to the granted requester.
- Sits between the GRU cell datapath and the tanh instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
FP_W, 32, float word width
TIMEOUT, 8, max WAIT cycles before error response (>=4)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request pending
req_data  in  N_REQ*FP_W  per-requester operand, slot i = bits [i*FP_W +: FP_W]
req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i]&req_ready[i]
resp_valid  out  N_REQ  one-hot, one-cycle result strobe
resp_data  out  FP_W  result, valid with resp_valid
resp_err  out  1  timeout flag, valid with resp_valid
tanh_start  out  1  start to tanh unit
tanh_in  out  FP_W  operand to tanh unit
tanh_out  in  FP_W  tanh unit result
tanh_done  in  1  tanh unit done pulse
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous:
  - state=IDLE; rr_ptr=N_REQ-1, so requester 0 has first priority.
  - tanh_start=0, tanh_in=0, resp_valid=0, resp_data=0, resp_err=0, wait_cnt=0.
  - req_ready=0.
  - Reset mid-operation abandons the transaction with no response. The tanh unit shares rstn.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding, from package).
- IDLE:
  - req_ready is combinational: one-hot at the first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, ... mod N_REQ. It is all-zero when no request is pending or state != IDLE.
  - On transfer: latch grant index and req_data slot into tanh_in; go to ISSUE.
- ISSUE:
  - tanh_start=1 for exactly this one cycle. It must never be held high longer, or the tanh unit re-pulses done.
  - tanh_in stays stable from ISSUE through RESP.
  - Clear wait_cnt; go to WAIT.
- WAIT:
  - wait_cnt increments each cycle.
  - If tanh_done=1: capture tanh_out into resp_data, resp_err=0, go to RESP.
  - Else if wait_cnt==TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
  - If done arrives in the same cycle as the timeout, done wins.
- RESP:
  - resp_valid[grant]=1 for one cycle; resp_data and resp_err are held.
  - rr_ptr<=grant; go to IDLE.
  - resp_valid clears next cycle; resp_data/resp_err hold until overwritten.
- tanh_done is ignored outside WAIT, so a stray pulse causes no response.
- Timing with nominal tanh latency (done 3 cycles after the start cycle):
  - accept in cycle 0, ISSUE in cycle 1, done seen in cycle 4, resp_valid in cycle 5, IDLE in cycle 6.
  - Accept-to-response latency is 5 cycles; throughput is one operation per 6 cycles.
- Requests are not queued: non-granted requesters hold req_valid and req_data until their req_ready.
- A requester may re-request in the cycle after its resp_valid. It then gets lowest priority if others are pending.
- Operands pass through unmodified: NaN, inf and denormal handling belong to the tanh unit.

Decomposition:
- Shared package (gru_pkg):
  - FP_W, state localparams S_IDLE/S_ISSUE/S_WAIT/S_RESP.
  - TANH_LATENCY=3 constant for the bench.
- One sub-module rr_arbiter:
  - parameter N_REQ; inputs req[N_REQ], ptr[$clog2(N_REQ)], en.
  - outputs gnt one-hot, gnt_idx.
  - purely combinational, instantiated once.
- The FSM, watchdog counter and data registers stay in tanh_share_ctrl.

Test Plan:
- Single request:
  - Stimulus: req_valid=0001, req_data[0]=0x3F800000 (1.0), real tanh model.
  - Response: req_ready=0001 in cycle 0, tanh_start high only in cycle 1, resp_valid=0001 in cycle 5, resp_data=0x3F42F7D6, resp_err=0.
- Round-robin fairness:
  - Stimulus: req_valid=1111 held continuously.
  - Response: grant order 0,1,2,3,0; consecutive req_ready pulses exactly 6 cycles apart; each resp_valid matches its grantee.
- Sign and saturation:
  - Stimulus: req_data=0xBF800000 (-1.0), then 0x41200000 (10.0).
  - Response: resp_data=0xBF42F7D6, then ~0x3F800000; no resp_err.
- Timeout:
  - Stimulus: tanh model never asserts done.
  - Response: resp_valid at accept+2+TIMEOUT (cycle 10 with default), resp_data=0, resp_err=1, then IDLE serves the next requester.
- Stray done and done-at-timeout:
  - Stimulus: tanh_done pulsed while IDLE; separately, done coincident with wait_cnt==TIMEOUT-1.
  - Response: no resp_valid in the first case; resp_err=0 with captured data in the second.
- Reset mid-WAIT:
  - Stimulus: rstn low during cycle 3 of a transaction.
  - Response: all outputs 0 immediately, busy=0, no resp_valid after release; next grant goes to requester 0.
